eaglesong_bit_matrix_engine: RTL and testbench

EAGLESONG_BIT_MATRIX_ENGINE -- requirements
Module: eaglesong_bit_matrix_engine

---
 rtl/eaglesong_bit_matrix_engine.sv | 157 +++++++++++++++
 tb/tb_eaglesong_bit_matrix_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_bit_matrix_engine.sv
// Eaglesong GF(2) bit-matrix multiply engine.
// out[r] = XOR of in[c] over every c with coefficient 1, where the coefficient is
// M[r][c], or M[c][r] when transpose is selected. LANES output words are produced per cycle.
module eaglesong_bit_matrix_engine #(
   parameter int unsigned N_WORDS = 16,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned LANES   = 1,
   parameter logic [N_WORDS*N_WORDS-1:0] MATRIX =
      256'hCA21_6513_DA9E_6D4F_FCB0_7E58_3F2C_1F96_0FCB_C022_E011_755F_FD78_BEBC_9F5E_8FAF
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_start,
   input  logic                        i_transpose,
   input  logic [N_WORDS*WORD_W-1:0]   i_state_in,
   output logic                        o_ready,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_valid,
   output logic [N_WORDS*WORD_W-1:0]   o_state_out
);

   localparam int unsigned LANES_C  = (LANES == 0) ? 1 : LANES;
   localparam int unsigned GROUPS   = N_WORDS / LANES_C;
   localparam int unsigned CNT_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam int unsigned ROW_W    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
   localparam int unsigned IDX_W    = (N_WORDS > 1) ? $clog2(N_WORDS * N_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

   // Reject lane counts that do not evenly tile the state.
   generate
      if (LANES < 1 || (N_WORDS % LANES_C) != 0) begin : g_bad_cfg
         $error("eaglesong_bit_matrix_engine: LANES must be >= 1 and divide N_WORDS");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                      r_state, w_state_nxt;
   logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
   logic                        r_ready, w_ready_nxt;
   logic                        r_busy, w_busy_nxt;
   logic                        r_done, w_done_nxt;
   logic                        r_valid, w_valid_nxt;
   logic [N_WORDS*WORD_W-1:0]   r_in;
   logic                        r_transpose;
   logic [N_WORDS*WORD_W-1:0]   r_state_out;
   logic                        w_capture;
   logic                        w_wr_en;
   logic [WORD_W-1:0]           w_lane [LANES_C];

   // State, counter and registered status flags.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ready <= w_ready_nxt;
         r_busy  <= w_busy_nxt;
         r_done  <= w_done_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   // Next-state logic; status flags are derived from the state being entered.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_wr_en     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            w_wr_en = 1'b1;
            if (r_cnt == CNT_LAST) begin
               w_state_nxt = S_DONE;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_ready_nxt = (w_state_nxt != S_RUN);
      w_busy_nxt  = (w_state_nxt == S_RUN);
      w_valid_nxt = (w_state_nxt == S_DONE);
      w_done_nxt  = (w_state_nxt == S_DONE) && (r_state == S_RUN);
   end

   // Operand and mode capture on an accepted start.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_in        <= '0;
         r_transpose <= 1'b0;
      end else if (w_capture) begin
         r_in        <= i_state_in;
         r_transpose <= i_transpose;
      end
   end

   // Row-group XOR network: one output word per lane for the current group.
   always_comb begin
      logic [ROW_W-1:0] v_row;
      logic [IDX_W-1:0] v_idx;
      v_row = '0;
      v_idx = '0;
      for (int l = 0; l < LANES_C; l++) begin
         w_lane[l] = '0;
         v_row     = ROW_W'(r_cnt) * ROW_W'(LANES_C) + ROW_W'(l);
         for (int c = 0; c < N_WORDS; c++) begin
            if (r_transpose) begin
               v_idx = IDX_W'(c) * IDX_W'(N_WORDS) + IDX_W'(v_row);
            end else begin
               v_idx = IDX_W'(v_row) * IDX_W'(N_WORDS) + IDX_W'(c);
            end
            if (MATRIX[v_idx]) begin
               w_lane[l] = w_lane[l] ^ r_in[c*WORD_W +: WORD_W];
            end
         end
      end
   end

   // Result write-back; words outside the current group keep their old value.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state_out <= '0;
      end else if (w_wr_en) begin
         for (int k = 0; k < N_WORDS; k++) begin
            if (r_cnt == CNT_W'(k / LANES_C)) begin
               r_state_out[k*WORD_W +: WORD_W] <= w_lane[k % LANES_C];
            end
         end
      end
   end

   assign o_ready     = r_ready;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_valid     = r_valid;
   assign o_state_out = r_state_out;

endmodule

// File: tb/tb_eaglesong_bit_matrix_engine.sv
// Scoreboard bench for eaglesong_bit_matrix_engine: four instances
// (default/LANES=1, identity/LANES=1, default/LANES=4, default/LANES=16).
module tb_eaglesong_bit_matrix_engine;

   localparam int unsigned VW = 512;
   localparam logic [255:0] EMAT =
      256'hCA21_6513_DA9E_6D4F_FCB0_7E58_3F2C_1F96_0FCB_C022_E011_755F_FD78_BEBC_9F5E_8FAF;

   function automatic logic [255:0] ident_f();
      logic [255:0] m;
      m = '0;
      for (int r = 0; r < 16; r++) m[r*17] = 1'b1;
      return m;
   endfunction
   localparam logic [255:0] IDENT = ident_f();

   typedef struct {
      logic [VW-1:0] val;
      int            cyc;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          st [4];
   logic          transpose;
   logic [VW-1:0] state_in;
   logic          rdy [4];
   logic          bsy [4];
   logic          dn  [4];
   logic          vld [4];
   logic [VW-1:0] outv [4];

   int   cyc = 0;
   int   n_vec = 0;
   int   n_fail = 0;
   exp_t q0[$], q1[$], q2[$], q3[$];

   eaglesong_bit_matrix_engine #(.LANES(1)) u_l1 (
      .i_clk(clk), .i_reset(rst), .i_start(st[0]), .i_transpose(transpose),
      .i_state_in(state_in), .o_ready(rdy[0]), .o_busy(bsy[0]), .o_done(dn[0]),
      .o_valid(vld[0]), .o_state_out(outv[0]));

   eaglesong_bit_matrix_engine #(.LANES(1), .MATRIX(IDENT)) u_id (
      .i_clk(clk), .i_reset(rst), .i_start(st[1]), .i_transpose(transpose),
      .i_state_in(state_in), .o_ready(rdy[1]), .o_busy(bsy[1]), .o_done(dn[1]),
      .o_valid(vld[1]), .o_state_out(outv[1]));

   eaglesong_bit_matrix_engine #(.LANES(4)) u_l4 (
      .i_clk(clk), .i_reset(rst), .i_start(st[2]), .i_transpose(transpose),
      .i_state_in(state_in), .o_ready(rdy[2]), .o_busy(bsy[2]), .o_done(dn[2]),
      .o_valid(vld[2]), .o_state_out(outv[2]));

   eaglesong_bit_matrix_engine #(.LANES(16)) u_l16 (
      .i_clk(clk), .i_reset(rst), .i_start(st[3]), .i_transpose(transpose),
      .i_state_in(state_in), .o_ready(rdy[3]), .o_busy(bsy[3]), .o_done(dn[3]),
      .o_valid(vld[3]), .o_state_out(outv[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference GF(2) matrix-vector product.
   function automatic logic [VW-1:0] model(input logic [255:0] m, input logic [VW-1:0] vin,
                                           input logic tr);
      logic [VW-1:0] res;
      res = '0;
      for (int rr = 0; rr < 16; rr++)
         for (int cc = 0; cc < 16; cc++)
            if (tr ? m[cc*16+rr] : m[rr*16+cc]) res[rr*32 +: 32] ^= vin[cc*32 +: 32];
      return res;
   endfunction

   // Word r is all ones where mask bit r is set.
   function automatic logic [VW-1:0] expand(input logic [15:0] mask);
      logic [VW-1:0] res;
      for (int r = 0; r < 16; r++) res[r*32 +: 32] = {32{mask[r]}};
      return res;
   endfunction

   function automatic int lat(input int sel);
      case (sel)
         2: return 4;
         3: return 1;
         default: return 16;
      endcase
   endfunction

   task automatic chk_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_i(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int sel, input logic [VW-1:0] v);
      exp_t e;
      e.val = v;
      e.cyc = cyc + 1 + lat(sel);
      case (sel)
         0: q0.push_back(e);
         1: q1.push_back(e);
         2: q2.push_back(e);
         default: q3.push_back(e);
      endcase
   endtask

   task automatic mon(input int sel);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (dn[sel]) begin
         case (sel)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
            default: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
         endcase
         if (!have) begin
            chk_i($sformatf("unexpected_done_dut%0d", sel), 1, 0);
         end else begin
            chk_v($sformatf("result_dut%0d", sel), outv[sel], e.val);
            chk_i($sformatf("done_cycle_dut%0d", sel), cyc, e.cyc);
            chk_i($sformatf("valid_at_done_dut%0d", sel), int'(vld[sel]), 1);
         end
      end
   endtask

   // Monitor: pop and compare whenever an instance pulses done.
   always @(negedge clk) begin
      if (!rst) begin
         for (int s = 0; s < 4; s++) mon(s);
      end
   end

   task automatic wait_done(input int sel, input int budget);
      int n;
      n = 0;
      while (!dn[sel] && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk_i($sformatf("done_seen_dut%0d", sel), int'(dn[sel]), 1);
   endtask

   task automatic go(input int sel, input logic [VW-1:0] v, input logic tr,
                     input logic [VW-1:0] exp);
      state_in = v;
      transpose = tr;
      st[sel] = 1'b1;
      push(sel, exp);
      @(negedge clk);
      st[sel] = 1'b0;
      wait_done(sel, 40);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [VW-1:0] vid, vhot, pv, nv;
      rst = 1'b1;
      transpose = 1'b0;
      state_in = '0;
      for (int s = 0; s < 4; s++) st[s] = 1'b0;
      for (int k = 0; k < 16; k++) begin
         vid[k*32 +: 32] = 32'h0000_0100 + 32'(k);
         pv[k*32 +: 32]  = (32'h9E37_79B9 * 32'(k + 1)) ^ (32'h0000_0F0F << k);
      end
      vhot = '0;
      vhot[31:0] = 32'hFFFF_FFFF;
      nv = ~pv;

      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         chk_i($sformatf("reset_flags_dut%0d", s),
               int'({rdy[s], bsy[s], dn[s], vld[s]}), 8);
         chk_v($sformatf("reset_out_dut%0d", s), outv[s], '0);
      end

      // Start held together with reset must be ignored.
      st[0] = 1'b1;
      @(negedge clk);
      st[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk_i("start_during_reset_busy", int'(bsy[0]), 0);
      chk_i("start_during_reset_ready", int'(rdy[0]), 1);

      go(1, vid, 1'b0, vid);
      go(0, vhot, 1'b0, expand(16'hD0B1));
      go(0, vhot, 1'b1, expand(16'h8FAF));
      go(2, vhot, 1'b0, expand(16'hD0B1));
      go(3, vhot, 1'b1, expand(16'h8FAF));
      for (int t = 0; t < 2; t++) begin
         go(2, pv, 1'(t), model(EMAT, pv, 1'(t)));
         go(0, pv, 1'(t), model(EMAT, pv, 1'(t)));
         go(3, pv, 1'(t), model(EMAT, pv, 1'(t)));
      end

      // Start during RUN is ignored; later input changes do not leak in.
      state_in = pv;
      transpose = 1'b0;
      st[0] = 1'b1;
      push(0, model(EMAT, pv, 1'b0));
      @(negedge clk);
      st[0] = 1'b0;
      repeat (2) @(negedge clk);
      state_in = nv;
      transpose = 1'b1;
      st[0] = 1'b1;
      chk_i("ready_in_run", int'(rdy[0]), 0);
      @(negedge clk);
      st[0] = 1'b0;
      state_in = vid;
      wait_done(0, 40);

      // Back-to-back start from DONE.
      state_in = vid;
      transpose = 1'b1;
      st[0] = 1'b1;
      push(0, model(EMAT, vid, 1'b1));
      @(negedge clk);
      st[0] = 1'b0;
      chk_i("b2b_valid_drops", int'(vld[0]), 0);
      chk_i("b2b_busy", int'(bsy[0]), 1);
      wait_done(0, 40);
      @(negedge clk);

      // Reset in the middle of a run.
      state_in = pv;
      transpose = 1'b0;
      st[0] = 1'b1;
      push(0, model(EMAT, pv, 1'b0));
      @(negedge clk);
      st[0] = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      chk_v("midrun_reset_out", outv[0], '0);
      chk_i("midrun_reset_valid", int'(vld[0]), 0);
      chk_i("midrun_reset_ready", int'(rdy[0]), 1);
      chk_i("midrun_reset_busy", int'(bsy[0]), 0);
      q0.delete();
      q1.delete();
      q2.delete();
      q3.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      go(0, pv, 1'b1, model(EMAT, pv, 1'b1));

      repeat (3) @(negedge clk);
      chk_i("scoreboard_leftover", q0.size() + q1.size() + q2.size() + q3.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
